// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with debug run/halt/step FSM and perf counters.
// Ports: clk, rst (sync, active-high); stallreq_id_i/stallreq_ex_i stall requests;
//   flush_req_i taken-branch squash request; dbg_halt_i/dbg_step_i debug controls;
//   stall_o[5:0] per-stage hold (PC, IF/ID, ID/EX, EX/MEM, MEM/WB, regfile WE gate);
//   flush_o IF/ID squash; halted_o FSM in HALT; cycle_cnt_o/stall_cnt_o perf counters;
//   wdog_err_o sticky stall watchdog error (only when PIPE_CTRL_WDOG_EN is defined).
module pipe_ctrl #(
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id_i,
    input  logic             stallreq_ex_i,
    input  logic             flush_req_i,
    input  logic             dbg_halt_i,
    input  logic             dbg_step_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             wdog_err_o
);
    typedef enum logic [1:0] {RUN, HALT, STEP} state_t;
    state_t state, next_state;
    logic req, active;
    assign req    = stallreq_ex_i | stallreq_id_i;
    assign active = state != HALT;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            cycle_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            state <= next_state;
            if (active) cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
            if (active && req) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end
    always_comb begin
        stall_o    = rst ? 6'b000000 :
                     !active ? 6'b111111 :
                     stallreq_ex_i ? 6'b001111 :
                     stallreq_id_i ? 6'b000111 : 6'b000000;
        next_state = state;
        case (state)
            RUN:     next_state = dbg_halt_i ? HALT : RUN;
            HALT:    next_state = !dbg_halt_i ? RUN : dbg_step_i ? STEP : HALT;
            // the step is consumed only on a cycle where PC actually advances
            STEP:    next_state = !dbg_halt_i ? RUN : !stall_o[0] ? HALT : STEP;
            default: next_state = RUN;
        endcase
    end
    assign flush_o  = flush_req_i & ~stall_o[1] & ~rst;
    assign halted_o = (state == HALT) & ~rst;
`ifdef PIPE_CTRL_WDOG_EN
    logic [15:0] wdog_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt   <= '0;
            wdog_err_o <= 1'b0;
        end else begin
            if (active) wdog_cnt <= !req ? 16'd0 :
                                    (wdog_cnt == 16'(WDOG_LIMIT)) ? wdog_cnt : wdog_cnt + 16'd1;
            if (wdog_cnt == 16'(WDOG_LIMIT)) wdog_err_o <= 1'b1;
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = |16'(WDOG_LIMIT);
    assign wdog_err_o  = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst, stallreq_id_i, stallreq_ex_i, flush_req_i, dbg_halt_i, dbg_step_i;
    logic [5:0]  stall_o;
    logic        flush_o, halted_o, wdog_err_o;
    logic [31:0] cycle_cnt_o, stall_cnt_o;
    int passed = 0;
    int total  = 0;
`ifdef PIPE_CTRL_WDOG_EN
    localparam logic [31:0] WD = 32'd1;
`else
    localparam logic [31:0] WD = 32'd0;
`endif

    pipe_ctrl #(.CNT_W(32), .WDOG_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i),
        .flush_req_i(flush_req_i), .dbg_halt_i(dbg_halt_i), .dbg_step_i(dbg_step_i),
        .stall_o(stall_o), .flush_o(flush_o), .halted_o(halted_o),
        .cycle_cnt_o(cycle_cnt_o), .stall_cnt_o(stall_cnt_o), .wdog_err_o(wdog_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1; stallreq_id_i = 0; stallreq_ex_i = 0; flush_req_i = 1; dbg_halt_i = 0; dbg_step_i = 0;
        #1;
        chk("rst_stall", 32'(stall_o), 32'h00);
        chk("rst_flush", 32'(flush_o), 0);
        chk("rst_halted", 32'(halted_o), 0);
        tick();
        chk("rst_cycle", cycle_cnt_o, 0);
        chk("rst_scnt", stall_cnt_o, 0);
        chk("rst_wdog", 32'(wdog_err_o), 0);
        rst = 0; flush_req_i = 0;
        tick(10);
        chk("idle_stall", 32'(stall_o), 32'h00);
        chk("idle_flush", 32'(flush_o), 0);
        chk("idle_cycle", cycle_cnt_o, 10);
        chk("idle_scnt", stall_cnt_o, 0);
        stallreq_id_i = 1; flush_req_i = 1;
        #1;
        chk("id_flush_defer", 32'(flush_o), 0);
        flush_req_i = 0;
        for (int i = 0; i < 3; i++) begin
            chk("id_stall", 32'(stall_o), 32'h07);
            tick();
        end
        stallreq_ex_i = 1;
        #1;
        chk("ex_stall", 32'(stall_o), 32'h0F);
        tick();
        stallreq_id_i = 0; stallreq_ex_i = 0;
        chk("req_scnt", stall_cnt_o, 4);
        chk("req_cycle", cycle_cnt_o, 14);
        dbg_halt_i = 1;
        #1;
        chk("halt_lat_halted", 32'(halted_o), 0);
        chk("halt_lat_stall", 32'(stall_o), 32'h00);
        tick();
        chk("halt_halted", 32'(halted_o), 1);
        chk("halt_stall", 32'(stall_o), 32'h3F);
        tick(3);
        chk("halt_cycle_frozen", cycle_cnt_o, 15);
        flush_req_i = 1; dbg_halt_i = 0;
        #1;
        chk("halt_flush_defer", 32'(flush_o), 0);
        chk("release_lat_stall", 32'(stall_o), 32'h3F);
        tick();
        chk("run_flush", 32'(flush_o), 1);
        chk("run_halted", 32'(halted_o), 0);
        chk("run_cycle", cycle_cnt_o, 15);
        flush_req_i = 0;
        tick();
        dbg_halt_i = 1;
        tick();
        chk("h2_cycle", cycle_cnt_o, 17);
        dbg_step_i = 1;
        tick();
        dbg_step_i = 0;
        chk("step_stall", 32'(stall_o), 32'h00);
        chk("step_halted", 32'(halted_o), 0);
        tick();
        chk("step_back_halted", 32'(halted_o), 1);
        chk("step_back_stall", 32'(stall_o), 32'h3F);
        chk("step_cycle", cycle_cnt_o, 18);
        dbg_step_i = 1;
        tick();
        dbg_step_i = 0; stallreq_ex_i = 1;
        #1;
        chk("stepx1_stall", 32'(stall_o), 32'h0F);
        tick();
        chk("stepx2_stall", 32'(stall_o), 32'h0F);
        chk("stepx2_halted", 32'(halted_o), 0);
        tick();
        stallreq_ex_i = 0;
        #1;
        chk("stepx3_stall", 32'(stall_o), 32'h00);
        tick();
        chk("stepx_halted", 32'(halted_o), 1);
        chk("stepx_cycle", cycle_cnt_o, 21);
        chk("stepx_scnt", stall_cnt_o, 6);
        dbg_step_i = 1;
        tick();
        dbg_step_i = 0; rst = 1; dbg_halt_i = 0;
        #1;
        chk("rst_step_stall", 32'(stall_o), 32'h00);
        tick();
        rst = 0;
        chk("post_rst_cycle", cycle_cnt_o, 0);
        chk("post_rst_scnt", stall_cnt_o, 0);
        chk("post_rst_halted", 32'(halted_o), 0);
        chk("post_rst_stall", 32'(stall_o), 32'h00);
        stallreq_ex_i = 1;
        tick(5);
        stallreq_ex_i = 0;
        chk("wdog_trip", 32'(wdog_err_o), WD);
        chk("wdog_scnt", stall_cnt_o, 5);
        tick(3);
        chk("wdog_sticky", 32'(wdog_err_o), WD);
        rst = 1;
        tick();
        rst = 0;
        chk("wdog_clear", 32'(wdog_err_o), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the five-stage Naive CPU. Merges stall requests from ID and EX into one per-stage stall vector, and gates branch flush. Provides a debug run/halt/single-step FSM, driven from the board observer controls, so a user can freeze the whole pipeline and advance it one cycle at a time. Also keeps cycle and stall performance counters that the observer can sample.

Parameters:
CNT_W, 32, width of cycle_cnt_o and stall_cnt_o.
WDOG_LIMIT, 64, consecutive stall-request cycles before the watchdog trips (optional feature only); legal range 1..65535.

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  synchronous reset, active-high
stallreq_id_i  in  1  ID requests a hold (load-use or operand not ready)
stallreq_ex_i  in  1  EX requests a hold (multi-cycle ALU op)
flush_req_i  in  1  ID resolved a taken branch; squash the IF/ID contents
dbg_halt_i  in  1  level; 1 = freeze the pipeline
dbg_step_i  in  1  single-cycle pulse; advance one instruction slot while halted
stall_o  out  6  per-stage hold: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] regfile write enable gate
flush_o  out  1  squash IF/ID this cycle
halted_o  out  1  1 while the FSM is in HALT
cycle_cnt_o  out  CNT_W  non-halted cycle count
stall_cnt_o  out  CNT_W  count of cycles with request-induced stall
wdog_err_o  out  1  sticky watchdog error

Behaviour:
- Reset (rst=1 at the clock edge): state=RUN; both counters 0; wdog counter 0; wdog_err_o=0. While rst=1, stall_o=6'b000000, flush_o=0, halted_o=0.
- FSM states are RUN, HALT and STEP; state is registered, and requests take effect the cycle after they are sampled.
  - RUN: go to HALT when dbg_halt_i=1.
  - HALT: if dbg_halt_i=0, go to RUN. Else if dbg_step_i=1, go to STEP. Else stay in HALT.
  - STEP: if dbg_halt_i=0, go to RUN. Else if stall_o[0]=0 this cycle (PC advanced), return to HALT. Else stay in STEP. The step is only consumed once PC actually moves.
  - If dbg_halt_i and dbg_step_i arrive in the same cycle while in RUN, go to HALT and ignore the step.
- stall_o is combinational from state and requests. Priority is highest first:
  - state==HALT: 6'b111111.
  - stallreq_ex_i: 6'b001111.
  - stallreq_id_i: 6'b000111.
  - otherwise: 6'b000000.
- STEP and RUN apply identical stall rules.
- flush_o = flush_req_i & ~stall_o[1] & ~rst. A flush during HALT or an EX/ID stall is deferred. ID holds flush_req_i asserted until flush_o is granted.
- halted_o = (state==HALT), registered.
- cycle_cnt_o increments every cycle with state!=HALT and wraps modulo 2^CNT_W.
- stall_cnt_o increments every cycle with state!=HALT and (stallreq_ex_i|stallreq_id_i), and wraps modulo 2^CNT_W.
- Counters hold during HALT. Reset in mid-step returns to RUN immediately and clears all counters.

Optional Feature:
PIPE_CTRL_WDOG_EN
- Defined:
  - A 16-bit counter increments every non-halted cycle with any stall request asserted.
  - It clears on any non-halted cycle with no request, and holds during HALT.
  - When it reaches WDOG_LIMIT, wdog_err_o sets to 1 on the next edge. It stays 1 until rst.
  - The counter saturates at WDOG_LIMIT.
  - Stall behaviour is unaffected; the watchdog only reports.
- Not defined: no counter logic; wdog_err_o tied to 0.

Test Plan:
1. Reset, then idle for 10 cycles with no requests -> stall_o=000000, flush_o=0, cycle_cnt_o=10, stall_cnt_o=0.
2. stallreq_id_i=1 for 3 cycles, then stallreq_ex_i=1 together with stallreq_id_i for 1 cycle -> stall_o=000111 for 3 cycles, then 001111; stall_cnt_o=4.
3. dbg_halt_i=1 at cycle N -> halted_o=1 and stall_o=111111 from N+1; cycle_cnt_o frozen. Assert flush_req_i during the halt -> flush_o=0. Release halt -> RUN; flush_o=1 on the first running cycle.
4. While halted, pulse dbg_step_i with no stall requests -> exactly one cycle with stall_o=000000, then HALT; cycle_cnt_o +1. Repeat with stallreq_ex_i=1 for 2 cycles -> STEP lasts 3 cycles (001111, 001111, 000000), then HALT.
5. Assert rst while in STEP -> next cycle state=RUN, counters 0, stall_o=000000.
6. With PIPE_CTRL_WDOG_EN defined and WDOG_LIMIT=4, hold stallreq_ex_i for 5 cycles -> wdog_err_o=1 after the 4th stalled cycle, and it stays 1 after the request drops until rst. Without the macro, wdog_err_o=0 throughout.
